// File: rtl/pipelining_pkg.sv
// Shared types and helpers for the pipelining blocks.
package pipelining_pkg;

    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    // Modulo-n increment of a round-robin pointer; correct for any n >= 1.
    function automatic int rr_next_ptr(input int ptr, input int n);
        int nxt;
        if (ptr + 32'sd1 >= n) begin
            nxt = 32'sd0;
        end else begin
            nxt = ptr + 32'sd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request scanning ptr+1, ptr+2, ... modulo NUM_REQ.
module rr_priority_picker
    import pipelining_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] idx,
    output logic                found
);

    logic [ID_WIDTH-1:0]  start_s;
    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [ID_WIDTH-1:0]  sel_s;
    logic [ID_WIDTH:0]    sum_s;

    // Rotate the doubled request vector so slot ptr+1 lands on bit 0, then take the lowest set bit.
    always_comb begin
        start_s = ID_WIDTH'(rr_next_ptr(int'(ptr), NUM_REQ));
        dbl_s   = {req, req};
        rot_s   = NUM_REQ'(dbl_s >> start_s);
        sel_s   = '0;
        found   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sel_s = rot_s[k] ? ID_WIDTH'(k) : sel_s;
            found = found | rot_s[k];
        end
        sum_s = {1'b0, start_s} + {1'b0, sel_s};
        if (sum_s >= (ID_WIDTH+1)'(NUM_REQ)) begin
            idx = ID_WIDTH'(sum_s - (ID_WIDTH+1)'(NUM_REQ));
        end else begin
            idx = sum_s[ID_WIDTH-1:0];
        end
        grant = '0;
        if (found) begin
            grant[idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready producers into one registered pipeline stage,
// with packet-atomic grant locking and pipeline-style flush/stall/busy.
module pipeline_rr_arbiter
    import pipelining_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            s_data_valid,
    output logic [NUM_REQ-1:0]            s_data_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data_data,
    input  logic [NUM_REQ-1:0]            s_data_last,
    output logic                          m_data_valid,
    input  logic                          m_data_ready,
    output logic [DATA_WIDTH-1:0]         m_data_data,
    output logic [ID_WIDTH-1:0]           m_data_id,
    output logic                          m_data_last,
    input  logic                          s_ctrl_flush,
    input  logic                          s_ctrl_stall,
    output logic                          s_status_busy
);

    localparam logic [ID_WIDTH-1:0] PTR_RESET = ID_WIDTH'(NUM_REQ - 1);

    arb_state_e            state_r, state_s;
    logic [ID_WIDTH-1:0]   owner_r, owner_s;
    logic [ID_WIDTH-1:0]   ptr_r, ptr_s;
    logic [ID_WIDTH-1:0]   id_r, id_s;
    logic                  full_r, full_s;
    logic                  last_r, last_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;

    logic [NUM_REQ-1:0]    pick_grant_s, grant_s;
    logic [ID_WIDTH-1:0]   pick_idx_s, gidx_s;
    logic                  pick_found_s, hit_s, accept_s, xfer_s, beat_last_s;
    logic [DATA_WIDTH-1:0] beat_data_s;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (s_data_valid),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Grant selection: a held lock pins the owner, even through bubbles; otherwise the picker decides.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        hit_s   = 1'b0;
        case (state_r)
            ARB_LOCKED: begin
                grant_s[owner_r] = 1'b1;
                gidx_s           = owner_r;
                hit_s            = s_data_valid[owner_r];
            end
            ARB_UNLOCKED: begin
                grant_s = pick_grant_s;
                gidx_s  = pick_idx_s;
                hit_s   = pick_found_s;
            end
            default: begin
                grant_s = '0;
                gidx_s  = '0;
                hit_s   = 1'b0;
            end
        endcase
        accept_s     = ~rst_i & ~s_ctrl_stall & ~s_ctrl_flush & (~full_r | m_data_ready);
        xfer_s       = accept_s & hit_s;
        s_data_ready = accept_s ? grant_s : '0;
        beat_data_s  = s_data_data[gidx_s*DATA_WIDTH +: DATA_WIDTH];
        beat_last_s  = s_data_last[gidx_s];
    end

    // Next state of the output stage, lock FSM and rr pointer; flush outranks stall.
    always_comb begin
        full_s  = full_r;
        data_s  = data_r;
        id_s    = id_r;
        last_s  = last_r;
        state_s = state_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        if (s_ctrl_flush) begin
            full_s  = 1'b0;
            data_s  = '0;
            id_s    = '0;
            last_s  = 1'b0;
            state_s = ARB_UNLOCKED;
            owner_s = '0;
            ptr_s   = PTR_RESET;
        end else if (s_ctrl_stall) begin
            full_s = full_r;
        end else begin
            if (xfer_s) begin
                full_s = 1'b1;
                data_s = beat_data_s;
                id_s   = gidx_s;
                last_s = beat_last_s;
            end else if (full_r & m_data_ready) begin
                full_s = 1'b0;
                data_s = '0;
                id_s   = '0;
                last_s = 1'b0;
            end else begin
                full_s = full_r;
            end
            case (state_r)
                ARB_UNLOCKED: begin
                    if (xfer_s) begin
                        ptr_s = gidx_s;
                        if (beat_last_s) begin
                            state_s = ARB_UNLOCKED;
                        end else begin
                            state_s = ARB_LOCKED;
                            owner_s = gidx_s;
                        end
                    end else begin
                        state_s = ARB_UNLOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer_s & beat_last_s) begin
                        state_s = ARB_UNLOCKED;
                    end else begin
                        state_s = ARB_LOCKED;
                    end
                end
                default: state_s = ARB_UNLOCKED;
            endcase
        end
    end

    // State registers, cleared asynchronously by rst_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_r  <= 1'b0;
            data_r  <= '0;
            id_r    <= '0;
            last_r  <= 1'b0;
            state_r <= ARB_UNLOCKED;
            owner_r <= '0;
            ptr_r   <= PTR_RESET;
        end else begin
            full_r  <= full_s;
            data_r  <= data_s;
            id_r    <= id_s;
            last_r  <= last_s;
            state_r <= state_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
        end
    end

    assign m_data_valid  = full_r;
    assign m_data_data   = data_r;
    assign m_data_id     = id_r;
    assign m_data_last   = last_r;
    assign s_status_busy = full_r | (state_r == ARB_LOCKED);

endmodule
